// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 initiator that turns a command + write-data stream into single
// or incrementing-burst cycles. Define WBM_TIMEOUT_EN to enable the ack timeout.
module wb_burst_master #(
  parameter int AW        = 26,
  parameter int DW        = 32,
  parameter int SW        = DW / 8,
  parameter int LENW      = 8,
  parameter int TO_CYCLES = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic            cmd_we,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  input  logic [SW-1:0]   wr_sel,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [SW-1:0]   wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_BUS   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [AW-1:0] ADDR_STEP = AW'(SW);

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] beat_q, beat_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [2:0]      cti_q, cti_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            cmd_take;
  logic            ack_seen;
  logic            last_beat;
  logic [LENW-1:0] beat_inc;
  logic            to_expired;

  // Burst type of beat idx in a burst of len+1 beats.
  function automatic logic [2:0] beat_cti(input logic [LENW-1:0] idx, input logic [LENW-1:0] len);
    logic [2:0] c;
    if (len == '0) begin
      c = CTI_CLASSIC;
    end else if (idx == len) begin
      c = CTI_END;
    end else begin
      c = CTI_INCR;
    end
    return c;
  endfunction

  assign cmd_take  = cmd_valid && (state_q == S_IDLE);
  assign ack_seen  = wb_ack_i && stb_q;
  assign last_beat = (beat_q == len_q);
  assign beat_inc  = beat_q + 1'b1;

`ifdef WBM_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYCLES + 1);

  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  assign to_expired = (to_cnt_q == TOW'(TO_CYCLES));

  // Counts strobed cycles without an ack; restarts for every beat.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (cmd_take || ack_seen || !stb_q) begin
      to_cnt_d = '0;
    end else if (!to_expired) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_d     = beat_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    cti_d      = cti_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_take) begin
          addr_d = cmd_addr;
          we_d   = cmd_we;
          len_d  = cmd_len;
          beat_d = '0;
          cyc_d  = 1'b1;
          cti_d  = beat_cti('0, cmd_len);
          err_d  = 1'b0;
          if (cmd_we) begin
            state_d = S_FETCH;
          end else begin
            stb_d   = 1'b1;
            sel_d   = '1;
            state_d = S_BUS;
          end
        end
      end

      S_FETCH: begin
        if (wr_valid) begin
          dat_d   = wr_data;
          sel_d   = wr_sel;
          stb_d   = 1'b1;
          cti_d   = beat_cti(beat_q, len_q);
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        if (ack_seen) begin
          beat_d = beat_inc;
          addr_d = addr_q + ADDR_STEP;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb_dat_i;
          end
          if (last_beat) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (we_q) begin
            // cti keeps 010 while the next write beat is fetched
            stb_d   = 1'b0;
            state_d = S_FETCH;
          end else begin
            cti_d = beat_cti(beat_inc, len_q);
          end
        end else if (to_expired) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      dat_q      <= '0;
      sel_q      <= '0;
      cti_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_FETCH);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_cti_o  = cti_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: Wishbone slave model with memory, write-stream driver,
// table-driven directed commands, randomized commands and reset/hang corner cases.
`timescale 1ns/1ps
module tb_wb_burst_master;
  localparam int AW        = 26;
  localparam int DW        = 32;
  localparam int SW        = 4;
  localparam int LENW      = 8;
  localparam int TO_CYCLES = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr = '0;
  logic            cmd_we = 1'b0;
  logic [LENW-1:0] cmd_len = '0;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_sel;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            busy, done, err;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [SW-1:0]   wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  always #5 clk = ~clk;

  wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .TO_CYCLES(TO_CYCLES)) dut (
    .wb_clk_i(clk), .wb_resetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memories: slave side and reference side ----------------
  logic [31:0] slv_mem [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] fill(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : fill(w);
  endfunction

  task automatic init_word(input logic [AW-1:0] a, input logic [31:0] v);
    slv_mem[int'(a[AW-1:2])] = v;
    ref_mem[int'(a[AW-1:2])] = v;
  endtask

  // ---------------- Wishbone slave model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  beat_t obs_q[$];
  int    ack_prob = 100;
  bit    ack_never = 0;
  int    cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    beat_t b;
    int w;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = $urandom;
      if (rst_n && wb_cyc_o && wb_stb_o && !ack_never && ($urandom_range(99) < ack_prob)) begin
        w      = int'(wb_addr_o[AW-1:2]);
        b.addr = wb_addr_o;
        b.we   = wb_we_o;
        b.sel  = wb_sel_o;
        b.cti  = wb_cti_o;
        b.data = wb_we_o ? wb_dat_o : '0;
        b.cyc  = cyc_cnt;
        if (wb_we_o) slv_mem[w] = merge(slv_mem.exists(w) ? slv_mem[w] : fill(w), wb_dat_o, wb_sel_o);
        else         wb_dat_i = slv_mem.exists(w) ? slv_mem[w] : fill(w);
        wb_ack_i = 1'b1;
        obs_q.push_back(b);
      end
    end
  end

  // ---------------- write-beat driver ----------------
  logic [DW-1:0] wq_data[$];
  logic [SW-1:0] wq_sel[$];
  int            wq_gap[$];

  initial begin
    bit prev_ready;
    int waited;
    prev_ready = 0;
    waited = 0;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 0;
        waited = 0;
        wr_valid = 1'b0;
      end else begin
        if (wr_valid && prev_ready && wq_data.size() > 0) begin
          void'(wq_data.pop_front());
          void'(wq_sel.pop_front());
          void'(wq_gap.pop_front());
          waited = 0;
        end
        prev_ready = wr_ready;
        if (wr_ready && wq_data.size() > 0) begin
          if (waited < wq_gap[0]) begin
            waited++;
            wr_valid = 1'b0;
          end else begin
            wr_valid = 1'b1;
            wr_data = wq_data[0];
            wr_sel = wq_sel[0];
          end
        end else begin
          // noise outside FETCH must be ignored
          wr_valid = ($urandom_range(3) == 0);
          wr_data = $urandom;
          wr_sel = 4'($urandom);
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [DW-1:0] rd_obs[$];
  int done_cnt = 0;
  int done_cyc = -1;
  bit done_with_rd = 0;
  int proto_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_valid) rd_obs.push_back(rd_data);
        if (done) begin
          done_cnt++;
          done_cyc = cyc_cnt;
          done_with_rd = rd_valid;
        end
        if (wr_ready && (!wb_cyc_o || wb_stb_o)) proto_err++;
        if (wb_stb_o && !wb_cyc_o) proto_err++;
        if (busy == cmd_ready) proto_err++;
      end
    end
  end

  task automatic clear_obs();
    obs_q.delete();
    rd_obs.delete();
    done_cnt = 0;
    done_cyc = -1;
    done_with_rd = 0;
    proto_err = 0;
  endtask

  // ---------------- one command against the reference model ----------------
  task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input int len, input logic [DW-1:0] d0,
                         input int gap_beat, input int gap_len, input bit hold, input string tag,
                         output logic [AW-1:0] last_addr, output logic [2:0] first_cti,
                         output logic [2:0] last_cti, output int nbeats);
    logic [AW-1:0] e_addr[$];
    logic [2:0]    e_cti[$];
    logic [DW-1:0] e_data[$];
    logic [SW-1:0] e_sel[$];
    logic [DW-1:0] e_rd[$];
    int n, last_ack;
    clear_obs();
    for (int k = 0; k <= len; k++) begin
      logic [AW-1:0] a;
      a = addr + AW'(4 * k);
      e_addr.push_back(a);
      e_cti.push_back(len == 0 ? 3'b000 : (k == len ? 3'b111 : 3'b010));
      if (we) begin
        e_data.push_back(k == 0 ? d0 : $urandom);
        e_sel.push_back(k == 0 ? 4'hF : 4'($urandom_range(1, 15)));
        wq_data.push_back(e_data[k]);
        wq_sel.push_back(e_sel[k]);
        wq_gap.push_back(gap_len < 0 ? $urandom_range(0, 2) : (k == gap_beat ? gap_len : 0));
      end else begin
        e_data.push_back('0);
        e_sel.push_back(4'hF);
        e_rd.push_back(ref_rd(int'(a[AW-1:2])));
      end
    end

    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, " cmd_ready"}, 96'(cmd_ready), 96'(1));
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = addr;
    cmd_len = LENW'(len);
    @(negedge clk); #1;
    chk({tag, " busy"}, 96'(busy), 96'(1));
    if (!hold) begin
      cmd_valid = 1'b0;
    end else begin
      cmd_we = ~we;
      cmd_addr = AW'($urandom);
      cmd_len = LENW'($urandom);
    end
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk({tag, " done_seen"}, 96'(done_cnt > 0), 96'(1));
    repeat (3) @(negedge clk);
    #1;

    chk({tag, " beats"}, 96'(obs_q.size()), 96'(len + 1));
    for (int k = 0; k < obs_q.size() && k <= len; k++)
      chk($sformatf("%s beat%0d", tag, k),
          96'({obs_q[k].addr, obs_q[k].we, obs_q[k].sel, obs_q[k].cti, obs_q[k].data}),
          96'({e_addr[k], we, e_sel[k], e_cti[k], e_data[k]}));
    chk({tag, " rd_count"}, 96'(rd_obs.size()), 96'(we ? 0 : len + 1));
    if (!we)
      for (int k = 0; k < rd_obs.size() && k <= len; k++)
        chk($sformatf("%s rd%0d", tag, k), 96'(rd_obs[k]), 96'(e_rd[k]));
    chk({tag, " done_count"}, 96'(done_cnt), 96'(1));
    last_ack = obs_q.size() > 0 ? obs_q[obs_q.size()-1].cyc : -100;
    chk({tag, " done_timing"}, 96'(done_cyc), 96'(last_ack + 1));
    chk({tag, " rd_with_done"}, 96'(done_with_rd), 96'(!we));
    chk({tag, " protocol"}, 96'(proto_err), 96'(0));

    if (we) for (int k = 0; k <= len; k++) begin
      int w;
      w = int'(e_addr[k][AW-1:2]);
      ref_mem[w] = merge(ref_rd(w), e_data[k], e_sel[k]);
    end
    nbeats    = obs_q.size();
    last_addr = nbeats > 0 ? obs_q[nbeats-1].addr : 'x;
    first_cti = nbeats > 0 ? obs_q[0].cti : 'x;
    last_cti  = nbeats > 0 ? obs_q[nbeats-1].cti : 'x;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    int            len;
    logic [DW-1:0] d0;
    int            gap_beat;
    int            gap_len;
    logic [AW-1:0] exp_last_addr;
    logic [2:0]    exp_first_cti;
    logic [2:0]    exp_last_cti;
    int            exp_beats;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] la;
    logic [2:0]    fc, lc;
    int            nb, n;

    vecs[0] = '{1'b1, 26'h0000100,   0, 32'hDEADBEEF, -1, 0, 26'h0000100, 3'b000, 3'b000,   1};
    vecs[1] = '{1'b0, 26'h0000200,   3, 32'h0,        -1, 0, 26'h000020C, 3'b010, 3'b111,   4};
    vecs[2] = '{1'b1, 26'h0000300,   7, 32'hCAFE0001,  3, 5, 26'h000031C, 3'b010, 3'b111,   8};
    vecs[3] = '{1'b0, 26'h3FFFFFC,   1, 32'h0,        -1, 0, 26'h0000000, 3'b010, 3'b111,   2};
    vecs[4] = '{1'b0, 26'h0000300,   7, 32'h0,        -1, 0, 26'h000031C, 3'b010, 3'b111,   8};
    vecs[5] = '{1'b1, 26'h3FFFFF8,   2, 32'hA5A5F00D, -1, 0, 26'h0000000, 3'b010, 3'b111,   3};
    vecs[6] = '{1'b0, 26'h3FFFFF8,   2, 32'h0,        -1, 0, 26'h0000000, 3'b010, 3'b111,   3};
    vecs[7] = '{1'b1, 26'h0000040, 255, 32'h01234567, -1, 0, 26'h000043C, 3'b010, 3'b111, 256};
    vecs[8] = '{1'b0, 26'h0000040, 255, 32'h0,        -1, 0, 26'h000043C, 3'b010, 3'b111, 256};
    vecs[9] = '{1'b0, 26'h0000044,   0, 32'h0,        -1, 0, 26'h0000044, 3'b000, 3'b000,   1};

    for (int k = 0; k < 4; k++) init_word(26'h200 + 26'(4 * k), 32'(k + 1));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset ctrl", 96'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, rd_valid, busy, done, err, wr_ready}), 96'(0));
    chk("reset data", 96'({wb_addr_o, wb_dat_o, rd_data}), 96'(0));
    chk("reset cmd_ready", 96'(cmd_ready), 96'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven directed commands
    ack_prob = 100;
    foreach (vecs[i]) begin
      run_cmd(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].d0, vecs[i].gap_beat, vecs[i].gap_len, 0,
              $sformatf("vec%0d", i), la, fc, lc, nb);
      chk($sformatf("vec%0d nbeats", i), 96'(nb), 96'(vecs[i].exp_beats));
      chk($sformatf("vec%0d last_addr", i), 96'(la), 96'(vecs[i].exp_last_addr));
      chk($sformatf("vec%0d first_cti", i), 96'(fc), 96'(vecs[i].exp_first_cti));
      chk($sformatf("vec%0d last_cti", i), 96'(lc), 96'(vecs[i].exp_last_cti));
      if (i == 1)
        for (int k = 0; k < 4; k++)
          chk($sformatf("vec1 data%0d", k), 96'(k < rd_obs.size() ? rd_obs[k] : 'x), 96'(k + 1));
      $display("[TB] vec%0d we=%0d addr=0x%07h len=%0d beats=%0d last_addr=0x%07h", i, vecs[i].we,
               vecs[i].addr, vecs[i].len, nb, la);
    end

    // randomized commands with stalling slave, write gaps and held cmd_valid
    ack_prob = 70;
    for (int i = 0; i < 25; i++) begin
      logic          rwe;
      logic [AW-1:0] ra;
      int            rlen;
      rwe  = 1'($urandom_range(1));
      rlen = $urandom_range(0, 15);
      ra   = ($urandom_range(3) == 0) ? (26'h3FFFFC0 + 26'(4 * $urandom_range(0, 15)))
                                      : 26'({$urandom_range(0, 511), 2'b00});
      run_cmd(rwe, ra, rlen, $urandom, -1, -1, 1'($urandom_range(1)), $sformatf("rnd%0d", i), la, fc, lc, nb);
      $display("[TB] rnd%0d we=%0d addr=0x%07h len=%0d beats=%0d", i, rwe, ra, rlen, nb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // reset after the 2nd ack of an 8-beat read
    ack_prob = 100;
    clear_obs();
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h500; cmd_len = 8'd7;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (obs_q.size() < 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_mid acks", 96'(obs_q.size()), 96'(2));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid outputs", 96'({wb_cyc_o, wb_stb_o, rd_valid, done, busy}), 96'(0));
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid cmd_ready", 96'(cmd_ready), 96'(1));
    repeat (5) @(negedge clk);
    #1;
    chk("rst_mid no_done", 96'(done_cnt), 96'(0));
    chk("rst_mid no_more_beats", 96'(obs_q.size()), 96'(2));
    $display("[TB] reset mid-burst: acks=%0d done=%0d", obs_q.size(), done_cnt);

    // slave never acks
    clear_obs();
    ack_never = 1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h600; cmd_len = 8'd0;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
`ifdef WBM_TIMEOUT_EN
    n = 0;
    while (done_cnt == 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("timeout done", 96'(done_cnt), 96'(1));
    chk("timeout err", 96'(err), 96'(1));
    chk("timeout cyc", 96'({wb_cyc_o, wb_stb_o}), 96'(0));
    ack_never = 0;
    repeat (2) @(negedge clk);
    run_cmd(1'b0, 26'h600, 0, '0, -1, 0, 0, "post_to", la, fc, lc, nb);
    chk("timeout err_cleared", 96'(err), 96'(0));
    $display("[TB] timeout: err cleared by next command");
`else
    repeat (100) @(negedge clk);
    #1;
    chk("hang cyc_stb", 96'({wb_cyc_o, wb_stb_o}), 96'(2'b11));
    chk("hang no_done", 96'({done_cnt != 0, err}), 96'(0));
    $display("[TB] hang: cyc=%0d after 100 cycles", wb_cyc_o);
    rst_n = 1'b0;
    ack_never = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(1'b0, 26'h600, 0, '0, -1, 0, 0, "post_hang", la, fc, lc, nb);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
